serial_add2_seq: RTL and testbench



---
 rtl/serial_add_pkg.sv | 20 ++
 rtl/add2_slice.sv | 26 ++
 rtl/serial_add2_seq.sv | 138 +++++++++++++
 tb/tb_serial_add2_seq.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// ============================================================================
//  Module      : serial_add_pkg
//  Description : Shared state encoding and slice width for serial_add2_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int SLICE_W = 2;

endpackage

`default_nettype wire

// File: rtl/add2_slice.sv
// ============================================================================
//  Module      : add2_slice
//  Description : Combinational 2-bit ripple-carry adder (two full-adder stages).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add2_slice (
    input  logic [1:0] x,
    input  logic [1:0] y,
    input  logic       ci,
    output logic [1:0] s,
    output logic       co
);

    logic w_c1;

    assign s[0] = x[0] ^ y[0] ^ ci;
    assign w_c1 = (x[0] & y[0]) | (x[0] & ci) | (y[0] & ci);

    assign s[1] = x[1] ^ y[1] ^ w_c1;
    assign co   = (x[1] & y[1]) | (x[1] & w_c1) | (y[1] & w_c1);

endmodule

`default_nettype wire

// File: rtl/serial_add2_seq.sv
// ============================================================================
//  Module      : serial_add2_seq
//  Description : Multi-precision adder that walks a 2-bit slice LSB-first.
//                Optional SERIAL_ADD_OVERFLOW_EN adds a signed-overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add2_seq
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH / SLICE_W + 1);

    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
            $error("serial_add2_seq: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [WIDTH-1:0]   r_psum;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         w_slice_s;
    logic               w_slice_co;
    logic [WIDTH-1:0]   w_psum_nxt;
    logic               w_last;

`ifdef SERIAL_ADD_OVERFLOW_EN
    logic               r_a_sign;
    logic               r_b_sign;
`endif

    add2_slice u_slice (
        .x  (r_op_a[1:0]),
        .y  (r_op_b[1:0]),
        .ci (r_carry),
        .s  (w_slice_s),
        .co (w_slice_co)
    );

    // New slice enters at the top; after WIDTH/2 shifts the LSB pair lands at bit 0.
    assign w_psum_nxt = WIDTH'({w_slice_s, r_psum} >> SLICE_W);
    assign w_last     = (r_cnt == CNT_W'(1));

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_psum   <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            sum      <= '0;
            cout     <= 1'b0;
`ifdef SERIAL_ADD_OVERFLOW_EN
            r_a_sign <= 1'b0;
            r_b_sign <= 1'b0;
            ovf      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op_a   <= a;
                        r_op_b   <= b;
                        r_carry  <= cin;
                        r_cnt    <= CNT_W'(WIDTH / SLICE_W);
`ifdef SERIAL_ADD_OVERFLOW_EN
                        r_a_sign <= a[WIDTH-1];
                        r_b_sign <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    r_op_a  <= r_op_a >> SLICE_W;
                    r_op_b  <= r_op_b >> SLICE_W;
                    r_psum  <= w_psum_nxt;
                    r_carry <= w_slice_co;
                    r_cnt   <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        sum  <= w_psum_nxt;
                        cout <= w_slice_co;
`ifdef SERIAL_ADD_OVERFLOW_EN
                        ovf  <= (r_a_sign == r_b_sign) &&
                                (w_psum_nxt[WIDTH-1] != r_a_sign);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_add2_seq.sv
// ============================================================================
//  Module      : tb_serial_add2_seq
//  Description : Directed self-checking bench for serial_add2_seq (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add2_seq;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVERFLOW_EN
    logic             ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [WIDTH-1:0] prev_sum = '0;

    serial_add2_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVERFLOW_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic run_add(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic cv, input logic [7:0] es, input logic ec,
                           input logic eo);
        int busy_cnt;
        int cycles;
        @(negedge clk);
        start = 1'b1; a = av; b = bv; cin = cv;
        @(negedge clk);
        start = 1'b0; a = 8'hxx; b = 8'hxx; cin = 1'bx;
        check({tag, "_hold_sum"}, 32'(sum), 32'(prev_sum));
        busy_cnt = 0;
        cycles   = 0;
        while (!done && cycles < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADD_OVERFLOW_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo) begin end
`endif
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        prev_sum = es;
    endtask

    initial begin
        int n_done;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;

        run_add("zero",   8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        run_add("chain",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_add("cin",    8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
        run_add("mixed",  8'h3C, 8'h4B, 1'b0, 8'h87, 1'b0, 1'b1);
        run_add("pos_ov", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_add("neg_ov", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);
        run_add("plain",  8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

        // Start re-asserted in RUN cycle 2 must be ignored.
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("ign_done_count", 32'(n_done), 32'd1);
        check("ign_sum",  32'(sum),  32'h30);
        check("ign_cout", 32'(cout), 32'd0);
        prev_sum = 8'h30;

        // Reset in RUN cycle 2 discards the operation.
        start = 1'b1; a = 8'h55; b = 8'h55; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_sum",  32'(sum),  32'd0);
        check("mrst_cout", 32'(cout), 32'd0);
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("mrst_no_done", 32'(n_done), 32'd0);
        prev_sum = 8'h00;
        run_add("after_rst", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
